// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package prog_loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned IDX_W          = $clog2(BYTES_PER_WORD);
  localparam int unsigned SHIFT_W        = 8 * (BYTES_PER_WORD - 1);

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
interface prog_loader_if #(
  parameter int unsigned ADDR_W = 7
) ();

  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  // master: serial receiver / memory side; slave: the loader
  modport master (
    output rx_valid, rx_data,
    input  rx_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/prog_loader_byte_packer.sv
// Packs bytes MSB first into 32-bit words; word_valid pulses the cycle after the 4th byte.
module prog_loader_byte_packer
  import prog_loader_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic [IDX_W-1:0] byte_idx,
  output logic             word_valid,
  output logic [31:0]      word
);

  logic [SHIFT_W-1:0] shift_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      byte_idx   <= '0;
      shift_q    <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else if (clear) begin
      byte_idx   <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (byte_valid) begin
        shift_q  <= {shift_q[SHIFT_W-9:0], byte_data};
        byte_idx <= IDX_W'(byte_idx + 1'b1);
        if (byte_idx == IDX_W'(BYTES_PER_WORD - 1)) begin
          word       <= {shift_q, byte_data};
          word_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Boot program loader: framed byte stream -> instruction memory, holds CPU in reset until loaded.
// Optional trailing checksum byte enabled by defining CHECKSUM_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned LEN_W  = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  prog_loader_if.slave  bus,
  output logic          cpu_reset,
  output logic          done,
  output logic          error
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  state_t            state, next_state;
  logic              rx_ready_q;
  logic [7:0]        len_hi;
  logic [LEN_W-1:0]  n_words;
  logic [LEN_W-1:0]  words_acc;
  logic [ADDR_W-1:0] addr_q;
  logic [IDX_W-1:0]  pk_idx;
  logic              pk_valid;
  logic [31:0]       pk_word;
`ifdef CHECKSUM_EN
  logic [7:0]        csum;
`endif

  logic             accept_c;
  logic             start_c;
  logic             word_done_c;
  logic [LEN_W-1:0] len_c;

  assign accept_c    = bus.rx_valid && rx_ready_q;
  assign start_c     = start && (state == IDLE || state == DONE || state == ERR);
  assign word_done_c = accept_c && (state == DATA) && (pk_idx == IDX_W'(BYTES_PER_WORD - 1));
  assign len_c       = LEN_W'({len_hi, bus.rx_data});

  assign bus.rx_ready  = rx_ready_q;
  assign bus.mem_we    = pk_valid;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = pk_word;

  prog_loader_byte_packer u_packer (
    .clock      (clock),
    .reset      (reset),
    .clear      (start_c),
    .byte_valid (accept_c && (state == DATA)),
    .byte_data  (bus.rx_data),
    .byte_idx   (pk_idx),
    .word_valid (pk_valid),
    .word       (pk_word)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE, ERR: if (start) next_state = LEN_HI;
      LEN_HI:          if (accept_c) next_state = LEN_LO;
      LEN_LO: begin
        if (accept_c) begin
          if (len_c > LEN_W'(DEPTH))  next_state = ERR;
`ifdef CHECKSUM_EN
          else if (len_c == '0)       next_state = CSUM;
`else
          else if (len_c == '0)       next_state = DONE;
`endif
          else                        next_state = DATA;
        end
      end
      DATA: begin
`ifdef CHECKSUM_EN
        // leave on the last byte so a back-to-back checksum byte lands in CSUM
        if (word_done_c && (LEN_W'(words_acc + 1'b1) == n_words)) next_state = CSUM;
`else
        if (pk_valid && (words_acc == n_words)) next_state = DONE;
`endif
      end
      CSUM: begin
`ifdef CHECKSUM_EN
        if (accept_c) next_state = (bus.rx_data == csum) ? DONE : ERR;
`endif
      end
      default: next_state = IDLE;
    endcase
  end

  // Status outputs registered from the next state
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_ready_q <= 1'b0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      rx_ready_q <= (next_state == LEN_HI) || (next_state == LEN_LO) ||
                    (next_state == DATA)   || (next_state == CSUM);
      cpu_reset  <= (next_state != DONE);
      done       <= (next_state == DONE);
      error      <= (next_state == ERR);
    end
  end

  // Length capture, word counter, write address and running checksum
  always_ff @(posedge clock) begin
    if (reset) begin
      len_hi    <= '0;
      n_words   <= '0;
      words_acc <= '0;
      addr_q    <= '0;
`ifdef CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      if (start_c) words_acc <= '0;
      if (accept_c && state == LEN_HI) len_hi  <= bus.rx_data;
      if (accept_c && state == LEN_LO) n_words <= len_c;
      if (word_done_c) begin
        words_acc <= LEN_W'(words_acc + 1'b1);
        addr_q    <= ADDR_W'(words_acc);
      end
`ifdef CHECKSUM_EN
      if (start_c)
        csum <= '0;
      else if (accept_c && state != CSUM)
        csum <= csum ^ bus.rx_data;
`endif
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader; frames follow the CHECKSUM_EN setting of the build.
module tb_prog_loader;

  typedef struct packed {
    logic [6:0]  addr;
    logic [31:0] data;
    logic [31:0] cyc;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic cpu_reset, done, error;

  prog_loader_if #(.ADDR_W(7)) bus ();

  prog_loader #(.ADDR_W(7), .LEN_W(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .bus       (bus),
    .cpu_reset (cpu_reset),
    .done      (done),
    .error     (error)
  );

  always #5 clock = ~clock;

  int          chk_cnt  = 0;
  int          pass_cnt = 0;
  logic [31:0] cyc      = 0;
  exp_t        sb[$];
  logic [7:0]  frame[$];
  logic [31:0] words[$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: every write must match the oldest expected word, one cycle after its last byte
  always @(negedge clock) begin
    exp_t e;
    if (!reset && bus.mem_we) begin
      if (sb.size() == 0) begin
        check("unexpected_write", 32'(bus.mem_addr), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
        check("wr_data", bus.mem_wdata, e.data);
        check("wr_latency", cyc, e.cyc);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, output bit ok);
    ok = 1'b0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (bus.rx_ready) begin
        @(posedge clock);
        #1;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
  endtask

  // Sends the first nbytes of frame; expected writes queued as each word's last byte is taken
  task automatic send_frame(input int nbytes, input int gap);
    int widx = 0;
    bit ok;
    for (int i = 0; i < nbytes; i++) begin
      send_byte(frame[i], ok);
      if (!ok) break;
      if (i >= 2 && ((i - 2) % 4) == 3 && widx < words.size()) begin
        sb.push_back('{addr: 7'(widx), data: words[widx], cyc: cyc});
        widx++;
      end
      if (gap > 0) begin
        bus.rx_valid = 1'b0;
        repeat (gap) @(posedge clock);
        #1;
      end
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_status(input string name, input bit exp_done, input bit exp_err);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done || error) break;
    end
    check({name, ".done"}, 32'(done), 32'(exp_done));
    check({name, ".error"}, 32'(error), 32'(exp_err));
    check({name, ".cpu_reset"}, 32'(cpu_reset), 32'(!exp_done));
    check({name, ".rx_ready"}, 32'(bus.rx_ready), 32'd0);
    check({name, ".pending_writes"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic load_good_frame();
    frame = '{8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'h8C, 8'h02, 8'h00, 8'h00};
`ifdef CHECKSUM_EN
    frame.push_back(8'hA8);
`endif
    words = '{32'h2001_0005, 32'h8C02_0000};
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    check("rst.cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst.done", 32'(done), 32'd0);
    check("rst.error", 32'(error), 32'd0);
    check("rst.rx_ready", 32'(bus.rx_ready), 32'd0);
    check("rst.mem_we", 32'(bus.mem_we), 32'd0);
    check("rst.mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst.mem_wdata", bus.mem_wdata, 32'd0);
    reset = 1'b0;

    // bytes offered in IDLE are not consumed
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h55;
    repeat (4) @(posedge clock);
    #1;
    check("idle.rx_ready", 32'(bus.rx_ready), 32'd0);
    bus.rx_valid = 1'b0;

    // good frame, back-to-back bytes
    load_good_frame();
    pulse_start();
    send_frame(frame.size(), 0);
    wait_status("good", 1'b1, 1'b0);

`ifdef CHECKSUM_EN
    // wrong checksum: both words still written, then ERR
    frame[10] = 8'hA9;
    pulse_start();
    check("restart.cpu_reset", 32'(cpu_reset), 32'd1);
    send_frame(frame.size(), 0);
    wait_status("badcsum", 1'b0, 1'b1);
`endif

    // N = 129 exceeds depth
    frame = '{8'h00, 8'h81};
    words = {};
    pulse_start();
    send_frame(2, 0);
    check("overlen.error_now", 32'(error), 32'd1);
    check("overlen.rx_ready", 32'(bus.rx_ready), 32'd0);
    wait_status("overlen", 1'b0, 1'b1);

    // good frame with 3-cycle gaps between bytes
    load_good_frame();
    pulse_start();
    send_frame(frame.size(), 3);
    wait_status("gaps", 1'b1, 1'b0);

    // reset after the 6th data byte, then a full reload
    load_good_frame();
    pulse_start();
    send_frame(8, 0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("midrst.cpu_reset", 32'(cpu_reset), 32'd1);
    check("midrst.rx_ready", 32'(bus.rx_ready), 32'd0);
    check("midrst.done", 32'(done), 32'd0);
    check("midrst.mem_we", 32'(bus.mem_we), 32'd0);
    check("midrst.word0_written", 32'(sb.size()), 32'd0);
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    pulse_start();
    send_frame(frame.size(), 0);
    wait_status("reload", 1'b1, 1'b0);

    // N = 0
    frame = '{8'h00, 8'h00};
`ifdef CHECKSUM_EN
    frame.push_back(8'h00);
`endif
    words = {};
    pulse_start();
    send_frame(frame.size(), 0);
    wait_status("zero_len", 1'b1, 1'b0);

    // N = 128 is the largest legal length: loader moves on to data
    frame = '{8'h00, 8'h80};
    pulse_start();
    send_frame(2, 0);
    check("maxlen.error", 32'(error), 32'd0);
    check("maxlen.rx_ready", 32'(bus.rx_ready), 32'd1);
    check("maxlen.cpu_reset", 32'(cpu_reset), 32'd1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;

    repeat (5) @(posedge clock);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
